decode_execute_register: RTL and testbench
==========================================

Name: decode_execute_register

Overview:
- Decode-to-execute (ID/EX) pipeline register of the in-order RISC-V core; captures decoded operands, register indices and control each cycle.
- Detects load-use hazards and inserts a one-cycle bubble, honours downstream memory stalls, and squashes on branch redirect.
- Its executeReadRegisterIndex1/2 outputs drive the execute-stage read indices of the two forwarding-unit instances.

Parameters:
- DATA_WIDTH, 32, width of PC, operand and immediate fields
- REG_INDEX_WIDTH, 5, width of register indices
- CTRL_WIDTH, 8, width of opaque ALU/branch/mem control bundle passed through

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- decodeValid  input  1  decode stage holds a real instruction
- decodePc  input  DATA_WIDTH  instruction PC
- decodeReadData1, decodeReadData2  input  DATA_WIDTH  register file read data
- decodeImmediate  input  DATA_WIDTH  sign-extended immediate
- decodeReadRegisterIndex1, decodeReadRegisterIndex2  input  REG_INDEX_WIDTH  source indices
- decodeWriteRegisterIndex  input  REG_INDEX_WIDTH  destination index
- decodeIsRegisterWrite  input  1  instruction writes rd
- decodeIsMemoryRead  input  1  instruction is a load
- decodeControl  input  CTRL_WIDTH  pass-through control
- memoryStall  input  1  downstream memory busy; whole pipeline freezes
- branchFlush  input  1  branch/jump taken in execute; squash decode instruction
- decodeStall  output  1  combinational; holds PC and IF/ID register
- executeValid, executePc, executeReadData1, executeReadData2, executeImmediate, executeReadRegisterIndex1, executeReadRegisterIndex2, executeWriteRegisterIndex, executeIsRegisterWrite, executeIsMemoryRead, executeControl  output  registered copies of the decode fields (same widths)

Behaviour:
- Reset (reset=1 at edge): all execute* outputs 0; state RUN. decodeStall=0 while reset high.
- Bubble = executeValid, executeIsRegisterWrite, executeIsMemoryRead, executeControl, all indices and data fields loaded with 0.
- loadUseHazard (combinational) = decodeValid & executeValid & executeIsMemoryRead & executeWriteRegisterIndex!=0 & (decodeReadRegisterIndex1==executeWriteRegisterIndex | decodeReadRegisterIndex2==executeWriteRegisterIndex).
- Per-edge priority, highest first:
  1. reset: clear everything.
  2. memoryStall: hold all registers, branchFlush ignored (branch stays in execute and reasserts). State HOLD.
  3. branchFlush: load bubble. State RUN.
  4. loadUseHazard: load bubble. State BUBBLE.
  5. else: load decode fields; executeValid=decodeValid. State RUN.
- decodeStall = ~reset & (memoryStall | (~branchFlush & loadUseHazard)).
- Latency: one cycle decode-to-execute. Load-use costs exactly one bubble: after the bubble the load sits in memory stage and the forwarding unit covers it, so the hazard deasserts by construction.
- States: RUN, HOLD, BUBBLE.
  - Any state -> HOLD when memoryStall=1.
  - HOLD -> RUN/BUBBLE per the priority list when memoryStall drops.
  - BUBBLE -> RUN on next non-stalled edge.
- Invariant: a second consecutive bubble from the same load never occurs. The bench asserts this.
- Index 0: a load writing x0 never triggers a bubble.
- Decode instruction with decodeValid=0 passes through as executeValid=0. Control and write-enable are still registered, but executeValid=0 qualifies them.
- Reset mid-stall or mid-bubble: reset wins, outputs 0 on the following cycle.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds output bubbleCount [31:0] and output stallCycleCount [31:0], both 0 on reset.
  - bubbleCount increments on each edge where a load-use bubble is inserted.
  - stallCycleCount increments on each edge with memoryStall=1.
  - Both saturate at 0xFFFFFFFF.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold reset 2 cycles with random decode inputs -> every execute* output 0, decodeStall=0.
- Load-use: execute holds load x5 (executeIsMemoryRead=1, wb idx 5, valid), decode reads idx2=5 -> decodeStall=1 that cycle; next cycle executeValid=0; following cycle the held instruction appears with executeReadRegisterIndex2=5. bubbleCount=1 if HAZARD_STATS_EN.
- x0 load: load writing idx 0, decode reads idx 0 -> decodeStall=0, no bubble, decode fields captured next cycle.
- Memory stall: memoryStall=1 for 3 cycles with executePc=0x100 -> outputs frozen at 0x100, decodeStall=1 all 3 cycles. stallCycleCount=3 if enabled.
- Flush vs hazard: branchFlush=1 with loadUseHazard true -> decodeStall=0, next executeValid=0, state RUN. Same with memoryStall=1 -> hold, flush ignored.
- Reset during BUBBLE: assert reset in bubble cycle -> all outputs 0 next cycle, normal capture resumes after release.

Source files
------------

// File: rtl/decode_execute_register.sv
// ============================================================================
// Module   : decode_execute_register
// Brief    : ID/EX pipeline register with load-use bubble insertion, memory
//            stall hold and branch squash. Optional macro HAZARD_STATS_EN adds
//            saturating bubble and stall-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_execute_register #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int CTRL_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef HAZARD_STATS_EN
  output logic [31:0]                bubbleCount,
  output logic [31:0]                stallCycleCount,
`endif
  input  logic                       decodeValid,
  input  logic [DATA_WIDTH-1:0]      decodePc,
  input  logic [DATA_WIDTH-1:0]      decodeReadData1,
  input  logic [DATA_WIDTH-1:0]      decodeReadData2,
  input  logic [DATA_WIDTH-1:0]      decodeImmediate,
  input  logic [REG_INDEX_WIDTH-1:0] decodeReadRegisterIndex1,
  input  logic [REG_INDEX_WIDTH-1:0] decodeReadRegisterIndex2,
  input  logic [REG_INDEX_WIDTH-1:0] decodeWriteRegisterIndex,
  input  logic                       decodeIsRegisterWrite,
  input  logic                       decodeIsMemoryRead,
  input  logic [CTRL_WIDTH-1:0]      decodeControl,
  input  logic                       memoryStall,
  input  logic                       branchFlush,
  output logic                       decodeStall,
  output logic                       executeValid,
  output logic [DATA_WIDTH-1:0]      executePc,
  output logic [DATA_WIDTH-1:0]      executeReadData1,
  output logic [DATA_WIDTH-1:0]      executeReadData2,
  output logic [DATA_WIDTH-1:0]      executeImmediate,
  output logic [REG_INDEX_WIDTH-1:0] executeReadRegisterIndex1,
  output logic [REG_INDEX_WIDTH-1:0] executeReadRegisterIndex2,
  output logic [REG_INDEX_WIDTH-1:0] executeWriteRegisterIndex,
  output logic                       executeIsRegisterWrite,
  output logic                       executeIsMemoryRead,
  output logic [CTRL_WIDTH-1:0]      executeControl
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HOLD   = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  typedef struct packed {
    logic                       valid;
    logic [DATA_WIDTH-1:0]      pc;
    logic [DATA_WIDTH-1:0]      readData1;
    logic [DATA_WIDTH-1:0]      readData2;
    logic [DATA_WIDTH-1:0]      immediate;
    logic [REG_INDEX_WIDTH-1:0] readIndex1;
    logic [REG_INDEX_WIDTH-1:0] readIndex2;
    logic [REG_INDEX_WIDTH-1:0] writeIndex;
    logic                       isRegisterWrite;
    logic                       isMemoryRead;
    logic [CTRL_WIDTH-1:0]      control;
  } payload_t;

  state_t   r_state;
  payload_t r_ex;
  payload_t w_dec;
  logic     w_loadUseHazard;

  assign w_dec = '{
    valid:           decodeValid,
    pc:              decodePc,
    readData1:       decodeReadData1,
    readData2:       decodeReadData2,
    immediate:       decodeImmediate,
    readIndex1:      decodeReadRegisterIndex1,
    readIndex2:      decodeReadRegisterIndex2,
    writeIndex:      decodeWriteRegisterIndex,
    isRegisterWrite: decodeIsRegisterWrite,
    isMemoryRead:    decodeIsMemoryRead,
    control:         decodeControl
  };

  // A bubble never sits behind itself: the state gate makes the single-bubble
  // property explicit even though executeValid=0 already implies it.
  assign w_loadUseHazard = decodeValid & r_ex.valid & r_ex.isMemoryRead &
                           (r_ex.writeIndex != '0) &
                           ((decodeReadRegisterIndex1 == r_ex.writeIndex) |
                            (decodeReadRegisterIndex2 == r_ex.writeIndex)) &
                           (r_state != S_BUBBLE);

  assign decodeStall = ~reset & (memoryStall | (~branchFlush & w_loadUseHazard));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex    <= '0;
      r_state <= S_RUN;
    end else if (memoryStall) begin
      r_state <= S_HOLD;
    end else if (branchFlush) begin
      r_ex    <= '0;
      r_state <= S_RUN;
    end else if (w_loadUseHazard) begin
      r_ex    <= '0;
      r_state <= S_BUBBLE;
    end else begin
      r_ex    <= w_dec;
      r_state <= S_RUN;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_bubbleCount;
  logic [31:0] r_stallCycleCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubbleCount     <= '0;
      r_stallCycleCount <= '0;
    end else begin
      if (memoryStall && (r_stallCycleCount != 32'hFFFF_FFFF))
        r_stallCycleCount <= r_stallCycleCount + 32'd1;
      if (!memoryStall && !branchFlush && w_loadUseHazard &&
          (r_bubbleCount != 32'hFFFF_FFFF))
        r_bubbleCount <= r_bubbleCount + 32'd1;
    end
  end

  assign bubbleCount     = r_bubbleCount;
  assign stallCycleCount = r_stallCycleCount;
`endif

  assign executeValid              = r_ex.valid;
  assign executePc                 = r_ex.pc;
  assign executeReadData1          = r_ex.readData1;
  assign executeReadData2          = r_ex.readData2;
  assign executeImmediate          = r_ex.immediate;
  assign executeReadRegisterIndex1 = r_ex.readIndex1;
  assign executeReadRegisterIndex2 = r_ex.readIndex2;
  assign executeWriteRegisterIndex = r_ex.writeIndex;
  assign executeIsRegisterWrite    = r_ex.isRegisterWrite;
  assign executeIsMemoryRead       = r_ex.isMemoryRead;
  assign executeControl            = r_ex.control;

endmodule

`default_nettype wire

// File: tb/tb_decode_execute_register.sv
// ============================================================================
// Module   : tb_decode_execute_register
// Brief    : Scoreboard bench for decode_execute_register (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_execute_register;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [7:0]  ctrl;
  } ex_t;

  typedef struct {
    int  id;
    ex_t e;
  } sb_t;

  logic clk;
  logic reset;
  logic memoryStall;
  logic branchFlush;
  ex_t  d;

  logic        decodeStall;
  logic        o_valid;
  logic [31:0] o_pc, o_rd1, o_rd2, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic        o_rw, o_mr;
  logic [7:0]  o_ctrl;
  ex_t         q;
`ifdef HAZARD_STATS_EN
  logic [31:0] bubbleCount;
  logic [31:0] stallCycleCount;
`endif

  sb_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  step_id  = 0;
  logic prev_hz = 1'b0;

  decode_execute_register #(
    .DATA_WIDTH(32), .REG_INDEX_WIDTH(5), .CTRL_WIDTH(8)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
`ifdef HAZARD_STATS_EN
    .bubbleCount               (bubbleCount),
    .stallCycleCount           (stallCycleCount),
`endif
    .decodeValid               (d.valid),
    .decodePc                  (d.pc),
    .decodeReadData1           (d.rd1),
    .decodeReadData2           (d.rd2),
    .decodeImmediate           (d.imm),
    .decodeReadRegisterIndex1  (d.rs1),
    .decodeReadRegisterIndex2  (d.rs2),
    .decodeWriteRegisterIndex  (d.rd),
    .decodeIsRegisterWrite     (d.rw),
    .decodeIsMemoryRead        (d.mr),
    .decodeControl             (d.ctrl),
    .memoryStall               (memoryStall),
    .branchFlush               (branchFlush),
    .decodeStall               (decodeStall),
    .executeValid              (o_valid),
    .executePc                 (o_pc),
    .executeReadData1          (o_rd1),
    .executeReadData2          (o_rd2),
    .executeImmediate          (o_imm),
    .executeReadRegisterIndex1 (o_rs1),
    .executeReadRegisterIndex2 (o_rs2),
    .executeWriteRegisterIndex (o_rd),
    .executeIsRegisterWrite    (o_rw),
    .executeIsMemoryRead       (o_mr),
    .executeControl            (o_ctrl)
  );

  assign q = '{valid: o_valid, pc: o_pc, rd1: o_rd1, rd2: o_rd2, imm: o_imm,
               rs1: o_rs1, rs2: o_rs2, rd: o_rd, rw: o_rw, mr: o_mr, ctrl: o_ctrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t mk(input logic v, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic rw, input logic mr);
    ex_t e;
    e.valid = v;
    e.pc    = pc;
    e.rd1   = pc + 32'h0000_1000;
    e.rd2   = pc ^ 32'hA5A5_0000;
    e.imm   = ~pc;
    e.rs1   = rs1;
    e.rs2   = rs2;
    e.rd    = rd;
    e.rw    = rw;
    e.mr    = mr;
    e.ctrl  = pc[7:0] ^ 8'h3C;
    return e;
  endfunction

  // Monitor: every cycle the register presents a new execute payload.
  initial begin
    sb_t s;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        s = sb.pop_front();
        n_assert++;
        if (q !== s.e) begin
          n_fail++;
          $display("FAIL exec_step%0d: got %h expected %h", s.id, q, s.e);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic ms, input logic bf,
                      input ex_t din, input ex_t exp, input logic exp_stall);
    logic hz;
    @(negedge clk);
    reset       = rst;
    memoryStall = ms;
    branchFlush = bf;
    d           = din;
    #1;
    n_assert++;
    if (decodeStall !== exp_stall) begin
      n_fail++;
      $display("FAIL stall_step%0d: got %b expected %b", step_id, decodeStall, exp_stall);
    end
    hz = decodeStall & ~ms & ~rst & ~bf;
    n_assert++;
    if (hz && prev_hz) begin
      n_fail++;
      $display("FAIL double_bubble_step%0d: got 2 consecutive bubbles expected 1", step_id);
    end
    if (rst) prev_hz = 1'b0;
    else if (!ms) prev_hz = hz;
    sb.push_back('{step_id, exp});
    step_id++;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic check_counts(input logic [31:0] eb, input logic [31:0] es);
    @(posedge clk);
    #1;
    n_assert++;
    if (bubbleCount !== eb) begin
      n_fail++;
      $display("FAIL bubbleCount: got %0d expected %0d", bubbleCount, eb);
    end
    n_assert++;
    if (stallCycleCount !== es) begin
      n_fail++;
      $display("FAIL stallCycleCount: got %0d expected %0d", stallCycleCount, es);
    end
  endtask
`endif

  initial begin
    ex_t bub, a, b, c, dd, e, f, g, h, i, r1, r2;
    bub = '0;
    reset = 1'b1; memoryStall = 1'b0; branchFlush = 1'b0; d = '0;

    r1 = mk(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
    r2 = mk(1'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b0);
    a  = mk(1'b1, 32'h0000_0100, 5'd1,  5'd2, 5'd5,  1'b1, 1'b1);  // lw x5
    b  = mk(1'b1, 32'h0000_0104, 5'd3,  5'd5, 5'd6,  1'b1, 1'b0);  // uses x5 via rs2
    c  = mk(1'b1, 32'h0000_0108, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1);  // lw x0
    dd = mk(1'b1, 32'h0000_010C, 5'd0,  5'd0, 5'd7,  1'b1, 1'b0);
    e  = mk(1'b1, 32'h0000_0100, 5'd8,  5'd9, 5'd10, 1'b1, 1'b0);
    f  = mk(1'b1, 32'h0000_0110, 5'd4,  5'd4, 5'd4,  1'b1, 1'b0);
    g  = mk(1'b1, 32'h0000_0114, 5'd1,  5'd2, 5'd11, 1'b1, 1'b1);  // lw x11
    h  = mk(1'b1, 32'h0000_0118, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0);  // uses x11 via rs1
    i  = mk(1'b0, 32'h0000_011C, 5'd2,  5'd3, 5'd13, 1'b1, 1'b1);  // invalid slot

    step(1'b1, 1'b0, 1'b0, r1,  bub, 1'b0);
    step(1'b1, 1'b1, 1'b1, r2,  bub, 1'b0);
    step(1'b0, 1'b0, 1'b0, a,   a,   1'b0);
    step(1'b0, 1'b0, 1'b0, b,   bub, 1'b1);
    step(1'b0, 1'b0, 1'b0, b,   b,   1'b0);
    step(1'b0, 1'b0, 1'b0, c,   c,   1'b0);
    step(1'b0, 1'b0, 1'b0, dd,  dd,  1'b0);
    step(1'b0, 1'b0, 1'b0, e,   e,   1'b0);
    step(1'b0, 1'b1, 1'b0, f,   e,   1'b1);
    step(1'b0, 1'b1, 1'b0, f,   e,   1'b1);
    step(1'b0, 1'b1, 1'b0, f,   e,   1'b1);
    step(1'b0, 1'b0, 1'b0, f,   f,   1'b0);
    step(1'b0, 1'b0, 1'b0, g,   g,   1'b0);
    step(1'b0, 1'b0, 1'b1, h,   bub, 1'b0);
    step(1'b0, 1'b0, 1'b0, g,   g,   1'b0);
    step(1'b0, 1'b1, 1'b1, h,   g,   1'b1);
    step(1'b0, 1'b0, 1'b0, h,   bub, 1'b1);
`ifdef HAZARD_STATS_EN
    check_counts(32'd2, 32'd4);
`endif
    step(1'b1, 1'b0, 1'b0, h,   bub, 1'b0);
    step(1'b0, 1'b0, 1'b0, h,   h,   1'b0);
    step(1'b0, 1'b0, 1'b0, i,   i,   1'b0);
`ifdef HAZARD_STATS_EN
    check_counts(32'd0, 32'd0);
`else
    @(posedge clk);
`endif

    repeat (3) @(posedge clk);
    #2;
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
